// File: rtl/control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback, flags illegal ops, counts retirements.
// Latency 2-5 cycles per instruction depending on class; no backpressure, the FSM advances every cycle.
module control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_BNE   = 6'h05,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Function,
    input  logic        Zero,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        PCSource,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        PCSel,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUCtrl,
    output logic [3:0]  State,
    output logic        IllegalOp,
    output logic        InstrDone,
    output logic [15:0] RetiredCount
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REXEC  = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] IEXEC  = 4'd9;
    localparam logic [3:0] IWB    = 4'd10;

    logic [3:0] next_state;
    logic [3:0] funct_ctrl;
    logic       funct_ok;
    logic       mem_write_raw, reg_write_raw, ir_write_raw;
    logic       pc_sel_raw, illegal_raw, done_raw;

    always_comb begin
        funct_ok   = 1'b1;
        funct_ctrl = 4'b0010;
        case (Function)
            6'h20:   funct_ctrl = 4'b0010;
            6'h22:   funct_ctrl = 4'b0110;
            6'h24:   funct_ctrl = 4'b0000;
            6'h25:   funct_ctrl = 4'b0001;
            6'h2A:   funct_ctrl = 4'b0111;
            6'h27:   funct_ctrl = 4'b1100;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        IorD          = 1'b0;
        MemRead       = 1'b0;
        mem_write_raw = 1'b0;
        MemtoReg      = 1'b0;
        ir_write_raw  = 1'b0;
        PCSource      = 1'b0;
        ALUSrcA       = 1'b0;
        reg_write_raw = 1'b0;
        RegDst        = 1'b0;
        pc_sel_raw    = 1'b0;
        ALUSrcB       = 2'b00;
        ALUCtrl       = 4'b0010;
        illegal_raw   = 1'b0;
        done_raw      = 1'b0;
        next_state    = FETCH;
        case (State)
            FETCH: begin
                MemRead      = 1'b1;
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b01;
                pc_sel_raw   = 1'b1;
                next_state   = DECODE;
            end
            DECODE: begin
                // ALU computes the branch target PC+1+imm speculatively
                ALUSrcB = 2'b10;
                if (Op == OP_LW || Op == OP_SW)
                    next_state = MEMADR;
                else if (Op == OP_RTYPE && funct_ok)
                    next_state = REXEC;
                else if (Op == OP_BEQ || Op == OP_BNE)
                    next_state = BRANCH;
                else if (Op == OP_ADDI)
                    next_state = IEXEC;
                else
                    illegal_raw = 1'b1;
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            REXEC: begin
                ALUSrcA    = 1'b1;
                ALUCtrl    = funct_ctrl;
                next_state = RWB;
            end
            RWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUCtrl    = 4'b0110;
                PCSource   = 1'b1;
                pc_sel_raw = (Op == OP_BNE) ? ~Zero : Zero;
                done_raw   = 1'b1;
            end
            IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = IWB;
            end
            IWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // State-changing strobes are suppressed while reset is held so nothing commits mid-abort
    assign MemWrite  = mem_write_raw & ~reset;
    assign RegWrite  = reg_write_raw & ~reset;
    assign IRWrite   = ir_write_raw  & ~reset;
    assign PCSel     = pc_sel_raw    & ~reset;
    assign IllegalOp = illegal_raw   & ~reset;
    assign InstrDone = done_raw      & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            State        <= FETCH;
            RetiredCount <= 16'd0;
        end else begin
            State <= next_state;
            if (done_raw)
                RetiredCount <= RetiredCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-class state paths and per-state control tables checked every cycle.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op, Function;
    logic        Zero;
    logic        IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource;
    logic        ALUSrcA, RegWrite, RegDst, PCSel, IllegalOp, InstrDone;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUCtrl, State;
    logic [15:0] RetiredCount;

    typedef struct packed {
        logic IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource;
        logic ALUSrcA, RegWrite, RegDst, PCSel;
        logic [1:0] ALUSrcB;
        logic [3:0] ALUCtrl;
        logic IllegalOp, InstrDone;
    } ctl_t;

    int          n_chk = 0;
    int          n_err = 0;
    logic        chk_en = 1'b0;
    logic [3:0]  m_state = 4'd0;
    logic [15:0] m_count = 16'd0;

    control_unit dut (
        .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSel(PCSel), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
        .State(State), .IllegalOp(IllegalOp), .InstrDone(InstrDone),
        .RetiredCount(RetiredCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction class: 0 R-type, 1 lw, 2 sw, 3 beq/bne, 4 addi, 5 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h23) return 1;
        if (op == 6'h2B) return 2;
        if (op == 6'h04 || op == 6'h05) return 3;
        if (op == 6'h08) return 4;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                            fn == 6'h25 || fn == 6'h2A || fn == 6'h27)) return 0;
        return 5;
    endfunction

    function automatic logic [3:0] alu_for(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            6'h27:   return 4'b1100;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected controls for a named step of the instruction sequence
    function automatic ctl_t model_ctl(input logic [3:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic z, input logic rst);
        ctl_t c;
        c = '0;
        c.ALUCtrl = 4'b0010;
        case (st)
            4'd0: begin c.MemRead = 1; c.IRWrite = 1; c.ALUSrcB = 2'b01; c.PCSel = 1; end
            4'd1: begin c.ALUSrcB = 2'b10; c.IllegalOp = (classify(op, fn) == 5); end
            4'd2: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            4'd3: begin c.IorD = 1; c.MemRead = 1; end
            4'd4: begin c.MemtoReg = 1; c.RegWrite = 1; c.InstrDone = 1; end
            4'd5: begin c.IorD = 1; c.MemWrite = 1; c.InstrDone = 1; end
            4'd6: begin c.ALUSrcA = 1; c.ALUCtrl = alu_for(fn); end
            4'd7: begin c.RegDst = 1; c.RegWrite = 1; c.InstrDone = 1; end
            4'd8: begin
                c.ALUSrcA = 1; c.ALUCtrl = 4'b0110; c.PCSource = 1; c.InstrDone = 1;
                c.PCSel = (op == 6'h05) ? ~z : z;
            end
            4'd9: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            4'd10: begin c.RegWrite = 1; c.InstrDone = 1; end
            default: ;
        endcase
        if (rst) begin
            c.MemWrite = 0; c.RegWrite = 0; c.IRWrite = 0;
            c.PCSel = 0; c.IllegalOp = 0; c.InstrDone = 0;
        end
        return c;
    endfunction

    always @(negedge clk) begin : cmp
        ctl_t e, a;
        if (chk_en) begin
            e = model_ctl(m_state, Op, Function, Zero, reset);
            a = {IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
                 RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl, IllegalOp, InstrDone};
            chk($sformatf("ctl_s%0d", m_state), 32'(a), 32'(e));
            chk("state", 32'(State), 32'(m_state));
            chk("count", 32'(RetiredCount), 32'(m_count));
        end
    end

    task automatic get_path(input int cls, output int path[$]);
        case (cls)
            0:       path = '{0, 1, 6, 7};
            1:       path = '{0, 1, 2, 3, 4};
            2:       path = '{0, 1, 2, 5};
            3:       path = '{0, 1, 8};
            4:       path = '{0, 1, 9, 10};
            default: path = '{0, 1};
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int path[$];
        int cls;
        Op = op; Function = fn; Zero = z;
        cls = classify(op, fn);
        get_path(cls, path);
        foreach (path[i]) begin
            m_state = 4'(path[i]);
            @(posedge clk); #1;
        end
        if (cls != 5) m_count = m_count + 16'd1;
        m_state = 4'd0;
    endtask

    // Run k steps of an instruction, then hold reset for two cycles starting in step k
    task automatic run_abort(input logic [5:0] op, input logic [5:0] fn, input int k);
        int path[$];
        Op = op; Function = fn; Zero = 1'b0;
        get_path(classify(op, fn), path);
        for (int i = 0; i < k; i++) begin
            m_state = 4'(path[i]);
            @(posedge clk); #1;
        end
        m_state = 4'(path[k]);
        reset = 1'b1;
        @(posedge clk); #1;
        m_state = 4'd0;
        m_count = 16'd0;
        chk("abort_state", 32'(State), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [5:0] rfn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

    initial begin
        reset = 1'b1; Op = 6'h00; Function = 6'h00; Zero = 1'b0;
        @(negedge clk);
        chk("rst_forced", 32'({MemWrite, RegWrite, IRWrite, PCSel, IllegalOp, InstrDone}), 32'd0);
        @(posedge clk); #1;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_count", 32'(RetiredCount), 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("fetch_vec", 32'({MemRead, IRWrite, ALUSrcB, PCSel}), 32'b11011);

        run_instr(6'h23, 6'h00, 1'b0);
        chk("lw_count", 32'(RetiredCount), 32'd1);
        foreach (rfn[i]) run_instr(6'h00, rfn[i], 1'b0);
        chk("r_count", 32'(RetiredCount), 32'd7);
        run_instr(6'h04, 6'h00, 1'b1);
        run_instr(6'h04, 6'h00, 1'b0);
        run_instr(6'h05, 6'h00, 1'b1);
        run_instr(6'h05, 6'h00, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0);
        run_instr(6'h08, 6'h00, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0);
        run_instr(6'h00, 6'h01, 1'b0);
        chk("illegal_count", 32'(RetiredCount), 32'd13);

        run_abort(6'h2B, 6'h00, 2);
        chk("sw_abort_count", 32'(RetiredCount), 32'd0);
        run_instr(6'h08, 6'h00, 1'b0);
        run_abort(6'h23, 6'h00, 3);
        run_instr(6'h23, 6'h00, 1'b0);
        chk("post_abort_count", 32'(RetiredCount), 32'd1);

        for (int i = 0; i < 65534; i++) run_instr(6'h04, 6'h00, 1'b0);
        chk("count_max", 32'(RetiredCount), 32'h0000FFFF);
        run_instr(6'h04, 6'h00, 1'b0);
        chk("count_wrap", 32'(RetiredCount), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle MIPS control FSM that drives the datapath's control inputs from its Op, Function and Zero outputs.
- Sequences fetch, decode, execute, memory and writeback for R-type (add/sub/and/or/slt/nor), lw, sw, beq, bne and addi.
- Flags unsupported instructions and counts retired instructions.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-if-equal opcode
OP_BNE, 6'h05, branch-if-not-equal opcode
OP_ADDI, 6'h08, add-immediate opcode

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Op  input  6  instruction[31:26] from the datapath instruction register
Function  input  6  instruction[5:0]
Zero  input  1  combinational ALUResult==0 from the datapath
IorD, MemRead, MemWrite, MemtoReg, IRWrite  output  1 each  datapath controls
PCSource, ALUSrcA, RegWrite, RegDst, PCSel  output  1 each  datapath controls
ALUSrcB  output  2  00=B, 01=constant 1, 1x=sign-extended immediate
ALUCtrl  output  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor
State  output  4  current state encoding (debug)
IllegalOp  output  1  one-cycle pulse on an unsupported opcode/funct
InstrDone  output  1  one-cycle pulse in the final state of each retired instruction
RetiredCount  output  16  retired-instruction counter

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10. Encodings 11-15 go to FETCH.
- Default outputs in every state: all 1-bit controls 0, ALUSrcB=00, ALUCtrl=0010. Each state lists only deviations.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCSel=1. Next state: DECODE.
- DECODE: ALUSrcB=10, producing ALUOut=PC+1+imm (word-addressed branch target). Next state by Op:
  - lw/sw: MEMADR
  - R-type with supported funct: REXEC
  - beq/bne: BRANCH
  - addi: IEXEC
  - otherwise: IllegalOp=1, then FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. The datapath's mdr captures the load at this edge. Next: MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0, InstrDone=1. Next: FETCH.
- MEMWR: IorD=1, MemWrite=1, InstrDone=1. Next: FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00. ALUCtrl decoded from funct:
  - 0x20 add -> 0010
  - 0x22 sub -> 0110
  - 0x24 and -> 0000
  - 0x25 or -> 0001
  - 0x2A slt -> 0111
  - 0x27 nor -> 1100
  - Next: RWB.
- RWB: RegDst=1, RegWrite=1, MemtoReg=0, InstrDone=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=0110, PCSource=1, InstrDone=1.
  - PCSel=Zero for beq, ~Zero for bne. This is the only Mealy output and is combinational on Zero in the same cycle.
  - Next: FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUCtrl=0010. Next: IWB.
- IWB: RegDst=0, RegWrite=1, MemtoReg=0, InstrDone=1. Next: FETCH.
- Latency in cycles including fetch: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, illegal 2.
- RetiredCount increments by 1 on each InstrDone edge and wraps 0xFFFF->0x0000. Illegal instructions are not counted.
- Reset:
  - While reset=1, MemWrite, RegWrite, IRWrite, PCSel, IllegalOp and InstrDone are forced 0 combinationally.
  - At the next edge, State=FETCH and RetiredCount=0.
  - Reset asserted in any state, including mid-lw or mid-sw, abandons the instruction. No write completes after the reset edge.
- After reset deasserts, outputs equal FETCH values.

Test Plan:
- Reset held 2 cycles from arbitrary state -> State=0, RetiredCount=0, MemWrite/RegWrite/IRWrite/PCSel=0 during reset; first post-reset cycle shows MemRead=1, IRWrite=1, ALUSrcB=01, PCSel=1.
- Op=0x23 (lw) -> State sequence 0,1,2,3,4; MEMRD has IorD=1, MemRead=1; MEMWB has MemtoReg=1, RegWrite=1, RegDst=0; InstrDone pulses once; RetiredCount +1.
- Op=0x00 with Function 0x20, 0x22, 0x24, 0x25, 0x2A, 0x27 -> ALUCtrl in REXEC = 0010, 0110, 0000, 0001, 0111, 1100; RWB has RegDst=1.
- Op=0x04 with Zero=1 then Zero=0 -> PCSel=1 then 0 in BRANCH, PCSource=1, ALUCtrl=0110; Op=0x05 gives the inverted PCSel.
- Op=0x3F, and Op=0x00 with Function 0x01 -> IllegalOp=1 in DECODE, next State=0, RetiredCount unchanged.
- Op=0x2B (sw) with reset asserted in MEMADR -> MemWrite never 1, State=0 after the edge; 65536 retired addi -> RetiredCount wraps to 0.
